// File: rtl/tetris_input_pkg.sv
// Shared move-command encodings and pending-bit layout for the button input path.
// Pending bits are indexed by command code, so a code selects its own pending bit.
package tetris_input_pkg;

  localparam int CMD_W = 2;

  localparam logic [CMD_W-1:0] CMD_DOWN   = 2'd0;
  localparam logic [CMD_W-1:0] CMD_ROTATE = 2'd1;
  localparam logic [CMD_W-1:0] CMD_RIGHT  = 2'd2;
  localparam logic [CMD_W-1:0] CMD_LEFT   = 2'd3;

  localparam int IDX_DOWN   = 0;
  localparam int IDX_ROTATE = 1;
  localparam int IDX_RIGHT  = 2;
  localparam int IDX_LEFT   = 3;

  // Fixed priority rotate > left > right > down; returns CMD_DOWN when nothing is pending.
  function automatic logic [CMD_W-1:0] prio_sel(input logic [3:0] pend);
    if (pend[IDX_ROTATE])     prio_sel = CMD_ROTATE;
    else if (pend[IDX_LEFT])  prio_sel = CMD_LEFT;
    else if (pend[IDX_RIGHT]) prio_sel = CMD_RIGHT;
    else                      prio_sel = CMD_DOWN;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Generic synchronous FIFO: registered storage, 1-cycle write-to-read, no fall-through.
// Push is refused when full unless a pop happens on the same edge; flush empties it.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head forced to zero when empty so stale storage never shows on the output.
  assign pop_dat = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/move_cmd_queue.sv
// Latches button pulses, serialises them by priority into a FIFO, 2-cycle press-to-valid.
// Full FIFO holds pending bits (repeat presses merge); optional CMD_DROP_CNT_EN counts merges.
module move_cmd_queue
  import tetris_input_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             down_signal,
  input  logic             rotate_signal,
  input  logic             right_signal,
  input  logic             left_signal,
  input  logic             flush,
  output logic             cmd_valid,
  output logic [CMD_W-1:0] cmd_code,
  input  logic             cmd_ready,
  output logic [CNT_W-1:0] cmd_count
`ifdef CMD_DROP_CNT_EN
  ,
  output logic [7:0]       drop_count
`endif
);

  logic [3:0]       pending;
  logic [3:0]       pulses;
  logic [3:0]       commit_mask;
  logic [CMD_W-1:0] commit_code;
  logic             commit;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;

  assign pulses      = {left_signal, right_signal, rotate_signal, down_signal};
  assign pop         = cmd_valid && cmd_ready;
  assign commit      = (|pending) && (!fifo_full || pop) && !flush;
  assign commit_code = prio_sel(pending);
  assign cmd_valid   = !fifo_empty;

  always_comb begin
    commit_mask = '0;
    if (commit) commit_mask[commit_code] = 1'b1;
  end

  // OR-ing pulses in after the clear lets a press on the committing bit survive.
  always_ff @(posedge clk) begin
    if (rst || flush) pending <= '0;
    else              pending <= (pending & ~commit_mask) | pulses;
  end

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W),
    .CNT_W (CNT_W)
  ) u_cmd_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (commit),
    .push_dat (commit_code),
    .pop      (pop),
    .flush    (flush),
    .pop_dat  (cmd_code),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (cmd_count)
  );

`ifdef CMD_DROP_CNT_EN
  logic [3:0] merged;
  logic [2:0] merge_sum;
  logic [8:0] drop_sum;

  assign merged    = pulses & pending & ~commit_mask;
  assign merge_sum = {2'b0, merged[0]} + {2'b0, merged[1]} + {2'b0, merged[2]} + {2'b0, merged[3]};
  assign drop_sum  = {1'b0, drop_count} + {6'b0, merge_sum};

  // Flush discards the cycle's pulses, so they are not merges; the count itself survives.
  always_ff @(posedge clk) begin
    if (rst)         drop_count <= '0;
    else if (!flush) drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end
`endif

endmodule

// File: tb/tb_move_cmd_queue.sv
// Directed bench for move_cmd_queue (DEPTH=4); drop_count checks only with CMD_DROP_CNT_EN.
module tb_move_cmd_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic       down_signal, rotate_signal, right_signal, left_signal;
  logic       flush;
  logic       cmd_valid;
  logic [1:0] cmd_code;
  logic       cmd_ready;
  logic [2:0] cmd_count;
`ifdef CMD_DROP_CNT_EN
  logic [7:0] drop_count;
`endif

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  move_cmd_queue #(.DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .down_signal   (down_signal),
    .rotate_signal (rotate_signal),
    .right_signal  (right_signal),
    .left_signal   (left_signal),
    .flush         (flush),
    .cmd_valid     (cmd_valid),
    .cmd_code      (cmd_code),
    .cmd_ready     (cmd_ready),
    .cmd_count     (cmd_count)
`ifdef CMD_DROP_CNT_EN
    ,
    .drop_count    (drop_count)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic all_pulses(input logic v);
    down_signal   = v;
    rotate_signal = v;
    right_signal  = v;
    left_signal   = v;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rotate_signal = 1'b1;
    tick();
    rotate_signal = 1'b0;
    tick();
    checks++; if (cmd_valid !== 1'b0) $display("FAIL reset_valid got=%0d exp=0", cmd_valid); else passed++;
    checks++; if (cmd_code !== 2'd0) $display("FAIL reset_code got=%0d exp=0", cmd_code); else passed++;
    checks++; if (cmd_count !== 3'd0) $display("FAIL reset_count got=%0d exp=0", cmd_count); else passed++;
`ifdef CMD_DROP_CNT_EN
    checks++; if (drop_count !== 8'd0) $display("FAIL reset_drop got=%0d exp=0", drop_count); else passed++;
`endif
    rst = 1'b0;
    tick();
    tick();
    checks++; if (cmd_valid !== 1'b0) $display("FAIL reset_pulse_ignored valid got=%0d exp=0", cmd_valid); else passed++;
  endtask

  task automatic test_single;
    cmd_ready = 1'b1;
    rotate_signal = 1'b1;
    tick();
    rotate_signal = 1'b0;
    checks++; if (cmd_valid !== 1'b0) $display("FAIL single_early valid got=%0d exp=0", cmd_valid); else passed++;
    tick();
    checks++; if (cmd_valid !== 1'b1) $display("FAIL single_valid got=%0d exp=1", cmd_valid); else passed++;
    checks++; if (cmd_code !== 2'd1) $display("FAIL single_code got=%0d exp=1", cmd_code); else passed++;
    checks++; if (cmd_count !== 3'd1) $display("FAIL single_count got=%0d exp=1", cmd_count); else passed++;
    tick();
    checks++; if (cmd_count !== 3'd0) $display("FAIL single_popped count got=%0d exp=0", cmd_count); else passed++;
    checks++; if (cmd_valid !== 1'b0) $display("FAIL single_popped valid got=%0d exp=0", cmd_valid); else passed++;
    cmd_ready = 1'b0;
  endtask

  task automatic test_simultaneous;
    logic [1:0] exp_code [4];
    exp_code[0] = 2'd1; exp_code[1] = 2'd3; exp_code[2] = 2'd2; exp_code[3] = 2'd0;
    cmd_ready = 1'b0;
    all_pulses(1'b1);
    tick();
    all_pulses(1'b0);
    repeat (4) tick();
    checks++; if (cmd_count !== 3'd4) $display("FAIL simul_count got=%0d exp=4", cmd_count); else passed++;
    cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cmd_valid !== 1'b1 || cmd_code !== exp_code[i])
        $display("FAIL simul_order[%0d] got valid=%0d code=%0d exp valid=1 code=%0d", i, cmd_valid, cmd_code, exp_code[i]);
      else passed++;
      tick();
    end
    cmd_ready = 1'b0;
    checks++; if (cmd_count !== 3'd0) $display("FAIL simul_drained count got=%0d exp=0", cmd_count); else passed++;
  endtask

  task automatic test_full_merge;
    int n_pop;
    logic all_left;
    cmd_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      left_signal = 1'b1;
      tick();
      left_signal = 1'b0;
      tick();
      tick();
    end
    checks++; if (cmd_count !== 3'd4) $display("FAIL merge_full_count got=%0d exp=4", cmd_count); else passed++;
`ifdef CMD_DROP_CNT_EN
    checks++; if (drop_count !== 8'd1) $display("FAIL merge_drop got=%0d exp=1", drop_count); else passed++;
`endif
    cmd_ready = 1'b1;
    n_pop = 0;
    all_left = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (cmd_valid === 1'b1) begin
        n_pop++;
        if (cmd_code !== 2'd3) all_left = 1'b0;
      end
      tick();
    end
    cmd_ready = 1'b0;
    checks++; if (n_pop != 5) $display("FAIL merge_drain_n got=%0d exp=5", n_pop); else passed++;
    checks++; if (all_left !== 1'b1) $display("FAIL merge_drain_codes all_left got=%0d exp=1", all_left); else passed++;
  endtask

  task automatic test_full_pop_commit;
    logic [1:0] exp_code [4];
    exp_code[0] = 2'd3; exp_code[1] = 2'd2; exp_code[2] = 2'd0; exp_code[3] = 2'd2;
    cmd_ready = 1'b0;
    all_pulses(1'b1);
    tick();
    all_pulses(1'b0);
    repeat (4) tick();
    right_signal = 1'b1;
    tick();
    right_signal = 1'b0;
    tick();
    tick();
    checks++; if (cmd_count !== 3'd4 || cmd_code !== 2'd1)
      $display("FAIL popcommit_pre got count=%0d code=%0d exp count=4 code=1", cmd_count, cmd_code); else passed++;
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    checks++; if (cmd_count !== 3'd4) $display("FAIL popcommit_count got=%0d exp=4", cmd_count); else passed++;
    checks++; if (cmd_code !== 2'd3) $display("FAIL popcommit_head got=%0d exp=3", cmd_code); else passed++;
    cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cmd_valid !== 1'b1 || cmd_code !== exp_code[i])
        $display("FAIL popcommit_order[%0d] got valid=%0d code=%0d exp valid=1 code=%0d", i, cmd_valid, cmd_code, exp_code[i]);
      else passed++;
      tick();
    end
    cmd_ready = 1'b0;
    checks++; if (cmd_count !== 3'd0) $display("FAIL popcommit_drained count got=%0d exp=0", cmd_count); else passed++;
  endtask

  task automatic test_flush;
    int n_valid;
    cmd_ready = 1'b0;
    all_pulses(1'b1);
    tick();
    all_pulses(1'b0);
    repeat (3) tick();
    checks++; if (cmd_count !== 3'd3) $display("FAIL flush_pre count got=%0d exp=3", cmd_count); else passed++;
    flush = 1'b1;
    down_signal = 1'b1;
    tick();
    flush = 1'b0;
    down_signal = 1'b0;
    checks++; if (cmd_valid !== 1'b0) $display("FAIL flush_valid got=%0d exp=0", cmd_valid); else passed++;
    checks++; if (cmd_count !== 3'd0) $display("FAIL flush_count got=%0d exp=0", cmd_count); else passed++;
    n_valid = 0;
    cmd_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (cmd_valid === 1'b1) n_valid++;
      tick();
    end
    cmd_ready = 1'b0;
    checks++; if (n_valid != 0) $display("FAIL flush_no_down valid_cycles got=%0d exp=0", n_valid); else passed++;
  endtask

  task automatic test_reset_mid;
    cmd_ready = 1'b0;
    left_signal = 1'b1;
    right_signal = 1'b1;
    tick();
    left_signal = 1'b0;
    right_signal = 1'b0;
    tick();
    tick();
    rotate_signal = 1'b1;
    tick();
    rotate_signal = 1'b0;
    checks++; if (cmd_count !== 3'd2) $display("FAIL rstmid_pre count got=%0d exp=2", cmd_count); else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (cmd_valid !== 1'b0 || cmd_code !== 2'd0 || cmd_count !== 3'd0)
      $display("FAIL rstmid_outputs got valid=%0d code=%0d count=%0d exp all 0", cmd_valid, cmd_code, cmd_count); else passed++;
`ifdef CMD_DROP_CNT_EN
    checks++; if (drop_count !== 8'd0) $display("FAIL rstmid_drop got=%0d exp=0", drop_count); else passed++;
`endif
    repeat (3) tick();
    checks++; if (cmd_valid !== 1'b0) $display("FAIL rstmid_no_rotate valid got=%0d exp=0", cmd_valid); else passed++;
    right_signal = 1'b1;
    tick();
    right_signal = 1'b0;
    checks++; if (cmd_valid !== 1'b0) $display("FAIL rstmid_right_early valid got=%0d exp=0", cmd_valid); else passed++;
    tick();
    checks++; if (cmd_valid !== 1'b1 || cmd_code !== 2'd2)
      $display("FAIL rstmid_right got valid=%0d code=%0d exp valid=1 code=2", cmd_valid, cmd_code); else passed++;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    cmd_ready = 1'b0;
    all_pulses(1'b0);
    test_reset();
    test_single();
    test_simultaneous();
    test_full_merge();
    test_full_pop_commit();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/move_cmd_queue.md
Name: move_cmd_queue

Overview:
- Sits between the four debounced button pulse sources (down, rotate, right, left) and the game control FSM.
- Captures each single-cycle move pulse and serialises simultaneous pulses by fixed priority.
- Buffers the resulting move commands in a small FIFO.
- Presents commands to the game logic over a valid/ready handshake, so no button press is lost while the game FSM is busy (line clear, piece spawn).

Parameters:
- DEPTH, 4, FIFO entries. Power of two, at least 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  input  1  system clock, 50 MHz
- rst  input  1  synchronous, active-high reset
- down_signal  input  1  one-cycle pulse from the down input handler
- rotate_signal  input  1  one-cycle pulse from the rotate input handler
- right_signal  input  1  one-cycle pulse from the right input handler
- left_signal  input  1  one-cycle pulse from the left input handler
- flush  input  1  discard all pending and queued commands (piece lock, game over)
- cmd_valid  output  1  FIFO head holds a command
- cmd_code  output  2  command at FIFO head
- cmd_ready  input  1  game FSM accepts the head command this cycle
- cmd_count  output  CNT_W  FIFO occupancy, 0..DEPTH
- drop_count  output  8  merged-press counter (only with CMD_DROP_CNT_EN)

Behaviour:
- Reset: the following are cleared on the first rising clk edge with rst=1, and stay cleared while rst is held:
  - pending[3:0]=0
  - FIFO empty
  - cmd_valid=0, cmd_code=0, cmd_count=0, drop_count=0
- Reset mid-operation discards everything in flight. Pulses arriving during reset are ignored.
- Stage 1, pending latch:
  - There is one pending bit per command type.
  - A pulse sets its bit at the next edge.
  - If a pulse arrives for a bit that is already set, the two presses merge into a single command.
  - If a pulse arrives in the same cycle its bit is being committed, set wins: the bit stays 1 and the new press is kept.
- Stage 2, commit:
  - At most one commit per cycle.
  - The highest-priority pending bit is written to the FIFO and cleared from pending.
  - Priority: rotate > left > right > down.
  - A commit is allowed when the FIFO is not full, or when it is full and a pop happens in the same cycle.
- Latency:
  - A pulse sampled at edge k is committed at edge k+1, and cmd_valid is high after edge k+1, provided the FIFO has room and no higher-priority bit is pending.
  - An isolated press therefore reaches the output in 2 cycles.
- Output handshake:
  - cmd_valid = (count != 0).
  - cmd_code is the FIFO head, registered from storage, and is stable while cmd_valid && !cmd_ready.
  - A pop occurs when cmd_valid && cmd_ready.
  - cmd_ready while empty has no effect.
- Simultaneous push and pop:
  - When not empty, count is unchanged.
  - When empty, only the push takes effect; no fall-through.
- Full FIFO: pending bits are held, not dropped. Further presses of a type that is already pending merge.
- Pointer arithmetic: read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count is tracked separately, CNT_W bits wide.
- Flush:
  - At the next edge, clears pending and empties the FIFO.
  - A button pulse in the same cycle as flush is discarded.
  - flush has priority over push and pop.
  - cmd_valid is 0 the cycle after flush.

Optional Feature:
- Macro: CMD_DROP_CNT_EN.
- When defined:
  - The drop_count port exists.
  - drop_count increments by 1 for each pulse that merges into an already-set pending bit. The set-wins-on-commit case does not count.
  - Several merges in one cycle add their sum.
  - drop_count saturates at 255.
  - It is cleared by rst only; flush does not clear it.
- When undefined: the port and its counter are absent, and the remaining behaviour is identical.

Decomposition:
- Package tetris_input_pkg holds:
  - command localparams CMD_DOWN=2'd0, CMD_ROTATE=2'd1, CMD_RIGHT=2'd2, CMD_LEFT=2'd3
  - CMD_W=2
  - the pending-bit index constants, in the same order
- One natural sub-module: cmd_fifo.
  - A generic synchronous FIFO with ports push, pop, flush, full, empty, count and parameters DEPTH, WIDTH.
  - Instantiated once.
- The priority encoder and pending latch stay in the top level.

Test Plan:
- Single rotate pulse at edge 10, cmd_ready=1 -> cmd_valid=1 with cmd_code=1 after edge 11, popped at edge 12; cmd_count returns to 0.
- All four pulses in the same cycle, cmd_ready=0 -> FIFO holds codes 1,3,2,0 in that order; cmd_count=4 after 4 commit cycles.
- cmd_ready=0, DEPTH=4: press left 6 times, 3 cycles apart ->
  - cmd_count=4 and pending[left]=1
  - with CMD_DROP_CNT_EN: drop_count=1
  - raising cmd_ready drains 5 left commands in total.
- FIFO full with a pending right, cmd_ready=1 for one cycle -> one pop and one commit on the same edge; cmd_count stays 4, and code 2 is enqueued at the tail.
- Queue holding 3 commands; assert flush together with a down pulse -> after the edge cmd_valid=0, cmd_count=0, pending=0, and no down command ever appears.
- Assert rst for one cycle while 2 commands are queued and rotate is pending -> all outputs 0 after the edge; the next right pulse yields cmd_code=2 two cycles later.
